// File: rtl/tx_rotator_if.sv
// ---------------------------------------------------------------------------
// tx_rotator_if
// Streaming bundle for the TX complex rotator.
//
// Handshake: a beat moves on a rising clk edge where valid & ready are both
// high. A producer holds valid and its payload stable until that edge, and
// valid never waits on ready. A consumer may drive ready from its own state
// only, never from the valid it is receiving.
//
// Input stream  (producer -> rotator): s_valid, s_ready, din_i, din_q,
//                                      cos_in, sin_in
// Output stream (rotator -> consumer): m_valid, m_ready, dout_i, dout_q,
//                                      sat_flag
// Modports:
//   master : the side that feeds samples in and takes results out
//   slave  : the rotator itself
// ---------------------------------------------------------------------------
interface tx_rotator_if #(
    parameter int WIDTH     = 16,
    parameter int DDS_WIDTH = 16
);
    logic                        s_valid;
    logic                        s_ready;
    logic signed [WIDTH-1:0]     din_i;
    logic signed [WIDTH-1:0]     din_q;
    logic signed [DDS_WIDTH-1:0] cos_in;
    logic signed [DDS_WIDTH-1:0] sin_in;

    logic                        m_valid;
    logic                        m_ready;
    logic signed [WIDTH-1:0]     dout_i;
    logic signed [WIDTH-1:0]     dout_q;
    logic                        sat_flag;

    modport master (
        output s_valid, din_i, din_q, cos_in, sin_in, m_ready,
        input  s_ready, m_valid, dout_i, dout_q, sat_flag
    );

    modport slave (
        input  s_valid, din_i, din_q, cos_in, sin_in, m_ready,
        output s_ready, m_valid, dout_i, dout_q, sat_flag
    );
endinterface

// File: rtl/tx_rotator.sv
// ---------------------------------------------------------------------------
// tx_rotator
// TX-side complex rotator. Upconverts baseband I/Q by the NCO phase supplied
// sample-aligned on cos_in/sin_in:
//     dout_i = I*cos - Q*sin
//     dout_q = Q*cos + I*sin
// with round-half-up scaling by 2^(DDS_WIDTH-1) and saturation to WIDTH.
//
// Pipeline: S1 input regs -> S2 products -> S3 sum/diff -> S4 round/sat/out.
// Each stage has its own valid bit; a stage loads when empty or when the
// stage after it loads, so bubbles collapse and four samples can be held
// under backpressure.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tx_rotator_if.slave (input and output streams)
//   sat_clr    : synchronous clear of sat_cnt
//   sat_cnt    : count of transferred outputs carrying sat_flag
//
// Optional feature macro: TX_ROT_SAT_CNT_EN
//   defined   : sat_cnt counts saturated output transfers, sticks at max,
//               sat_clr clears it (clear wins over increment)
//   undefined : sat_cnt tied to 0, sat_clr ignored
// ---------------------------------------------------------------------------
module tx_rotator #(
    parameter int WIDTH     = 16,
    parameter int DDS_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tx_rotator_if.slave          bus,
    input  logic                 sat_clr,
    output logic [CNT_WIDTH-1:0] sat_cnt
);
    localparam int PW = WIDTH + DDS_WIDTH;  // product width
    localparam int SW = PW + 1;             // sum/diff width, cannot overflow
    localparam int SH = DDS_WIDTH - 1;      // scaling shift

    localparam logic signed [SW-1:0] RND =
        {{(SW-DDS_WIDTH+1){1'b0}}, 1'b1, {(DDS_WIDTH-2){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Held low through reset and for the first edge after release so that
    // s_ready only rises once the pipeline is known empty.
    logic run;

    logic v1, v2, v3, v4;
    logic ld1, ld2, ld3, ld4;
    logic s_ready_int;
    logic accept;

    logic signed [WIDTH-1:0]     s1_i, s1_q;
    logic signed [DDS_WIDTH-1:0] s1_c, s1_s;
    logic signed [PW-1:0]        s2_ic, s2_qs, s2_qc, s2_is;
    logic signed [SW-1:0]        s3_i, s3_q;
    logic signed [WIDTH-1:0]     s4_i, s4_q;
    logic                        s4_sat;

    logic signed [SW-1:0]        rnd_i, rnd_q;
    logic signed [WIDTH-1:0]     nxt_i, nxt_q;
    logic                        clip_i, clip_q;

    // Load chain from the output backwards; purely from valids and m_ready.
    always_comb begin
        ld4 = ~v4 | bus.m_ready;
        ld3 = ~v3 | ld4;
        ld2 = ~v2 | ld3;
        ld1 = ~v1 | ld2;
    end

    assign s_ready_int = run & ld1;
    assign accept      = bus.s_valid & s_ready_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // S1: register inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_i <= '0;
            s1_q <= '0;
            s1_c <= '0;
            s1_s <= '0;
        end else if (ld1) begin
            v1 <= accept;
            if (accept) begin
                s1_i <= bus.din_i;
                s1_q <= bus.din_q;
                s1_c <= bus.cos_in;
                s1_s <= bus.sin_in;
            end
        end
    end

    // S2: four full-width signed products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            s2_ic <= '0;
            s2_qs <= '0;
            s2_qc <= '0;
            s2_is <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                s2_ic <= PW'(s1_i) * PW'(s1_c);
                s2_qs <= PW'(s1_q) * PW'(s1_s);
                s2_qc <= PW'(s1_q) * PW'(s1_c);
                s2_is <= PW'(s1_i) * PW'(s1_s);
            end
        end
    end

    // S3: rotation by +phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            s3_i <= '0;
            s3_q <= '0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                s3_i <= SW'(s2_ic) - SW'(s2_qs);
                s3_q <= SW'(s2_qc) + SW'(s2_is);
            end
        end
    end

    // Round half up, then clamp. (-FS)*(-FS) lands one LSB above +FS after
    // scaling, so the clamp is what keeps it from wrapping negative.
    always_comb begin
        rnd_i  = (s3_i + RND) >>> SH;
        rnd_q  = (s3_q + RND) >>> SH;
        clip_i = (rnd_i > SAT_MAX) || (rnd_i < SAT_MIN);
        clip_q = (rnd_q > SAT_MAX) || (rnd_q < SAT_MIN);
        nxt_i  = rnd_i[WIDTH-1:0];
        nxt_q  = rnd_q[WIDTH-1:0];
        if (rnd_i > SAT_MAX) nxt_i = OUT_MAX;
        if (rnd_i < SAT_MIN) nxt_i = OUT_MIN;
        if (rnd_q > SAT_MAX) nxt_q = OUT_MAX;
        if (rnd_q < SAT_MIN) nxt_q = OUT_MIN;
    end

    // S4: output register; only moves when empty or the output is taken,
    // so the payload is stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v4     <= 1'b0;
            s4_i   <= '0;
            s4_q   <= '0;
            s4_sat <= 1'b0;
        end else if (ld4) begin
            v4 <= v3;
            if (v3) begin
                s4_i   <= nxt_i;
                s4_q   <= nxt_q;
                s4_sat <= clip_i | clip_q;
            end
        end
    end

    assign bus.s_ready  = s_ready_int;
    assign bus.m_valid  = v4;
    assign bus.dout_i   = s4_i;
    assign bus.dout_q   = s4_q;
    assign bus.sat_flag = s4_sat;

`ifdef TX_ROT_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (v4 && bus.m_ready && s4_sat && !(&sat_cnt)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_tx_rotator.sv
// ---------------------------------------------------------------------------
// tb_tx_rotator
// Bench for tx_rotator. Inputs change 1 time unit after the rising edge; the
// scoreboard looks at the bus on the falling edge, where it sees exactly the
// values the next rising edge will act on. An accepted input pushes the
// golden result; a taken output pops and compares.
// ---------------------------------------------------------------------------
module tb_tx_rotator;
    localparam int W = 16;
    localparam int D = 16;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sat_clr = 1'b0;
    logic [C-1:0] sat_cnt;

    tx_rotator_if #(.WIDTH(W), .DDS_WIDTH(D)) bus ();

    tx_rotator #(.WIDTH(W), .DDS_WIDTH(D), .CNT_WIDTH(C)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sat_clr (sat_clr),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_exp;
    logic [2*W:0] mon_got;

`ifdef TX_ROT_SAT_CNT_EN
    localparam int SAT_CNT_AFTER_TWO = 2;
`else
    localparam int SAT_CNT_AFTER_TWO = 0;
`endif

    // Golden model: {sat_flag, dout_i, dout_q}, computed in 64-bit integers.
    function automatic logic [2*W:0] model(input logic signed [W-1:0] i,
                                           input logic signed [W-1:0] q,
                                           input logic signed [D-1:0] c,
                                           input logic signed [D-1:0] s);
        longint pi, pq, ri, rq, mx, mn;
        logic signed [W-1:0] oi, oq;
        logic sat;
        mx = (longint'(1) <<< (W-1)) - 1;
        mn = -(longint'(1) <<< (W-1));
        pi = longint'(i) * longint'(c) - longint'(q) * longint'(s);
        pq = longint'(q) * longint'(c) + longint'(i) * longint'(s);
        ri = (pi + (longint'(1) <<< (D-2))) >>> (D-1);
        rq = (pq + (longint'(1) <<< (D-2))) >>> (D-1);
        sat = 1'b0;
        if (ri > mx) begin ri = mx; sat = 1'b1; end
        if (ri < mn) begin ri = mn; sat = 1'b1; end
        if (rq > mx) begin rq = mx; sat = 1'b1; end
        if (rq < mn) begin rq = mn; sat = 1'b1; end
        oi = W'(ri);
        oq = W'(rq);
        return {sat, oi, oq};
    endfunction

    // Scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                mon_got = {bus.sat_flag, bus.dout_i, bus.dout_q};
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_extra: got sat/i/q=%0b/%0d/%0d, expected no output",
                             bus.sat_flag, bus.dout_i, bus.dout_q);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp)
                        $display("FAIL scoreboard_data: got sat/i/q=%0b/%0d/%0d, expected %0b/%0d/%0d",
                                 mon_got[2*W], $signed(mon_got[2*W-1:W]), $signed(mon_got[W-1:0]),
                                 mon_exp[2*W], $signed(mon_exp[2*W-1:W]), $signed(mon_exp[W-1:0]));
                    else
                        passed++;
                end
            end
            if (bus.s_valid && bus.s_ready)
                exp_q.push_back(model(bus.din_i, bus.din_q, bus.cos_in, bus.sin_in));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [W-1:0] i, input logic signed [W-1:0] q,
                        input logic signed [D-1:0] c, input logic signed [D-1:0] s);
        bit ok;
        int n;
        bus.s_valid = 1'b1;
        bus.din_i   = i;
        bus.din_q   = q;
        bus.cos_in  = c;
        bus.sin_in  = s;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = bus.s_ready;
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, expected 1", bus.s_ready, n);
        end
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.m_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.m_valid) begin
            checks++;
            $display("FAIL wait_out_timeout: m_valid=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: %0d samples still expected, required 0", exp_q.size());
        else
            passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.din_i   = '0;
        bus.din_q   = '0;
        bus.cos_in  = '0;
        bus.sin_in  = '0;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.m_valid, bus.s_ready, bus.sat_flag, bus.dout_i, bus.dout_q} !== '0)
            $display("FAIL reset_outputs: m_valid/s_ready/sat/i/q=%0b/%0b/%0b/%0d/%0d, required all 0",
                     bus.m_valid, bus.s_ready, bus.sat_flag, bus.dout_i, bus.dout_q);
        else
            passed++;
        checks++;
        if (sat_cnt !== '0) $display("FAIL reset_sat_cnt: got %0d, required 0", sat_cnt);
        else passed++;
        rst_n = 1'b1;
        #2;
        checks++;
        if (bus.s_ready !== 1'b0) $display("FAIL reset_sready_early: got %0b, required 0", bus.s_ready);
        else passed++;
        tick();
        checks++;
        if (bus.s_ready !== 1'b1) $display("FAIL reset_sready_rise: got %0b, required 1", bus.s_ready);
        else passed++;
    endtask

    task automatic test_identity();
        bit early;
        bus.m_ready = 1'b1;
        send(16'sd1000, -16'sd2000, 16'sd32767, 16'sd0);
        early = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bus.m_valid) early = 1'b1;
            if (k < 2) tick();
        end
        tick();
        checks++;
        if (early || bus.m_valid !== 1'b1)
            $display("FAIL identity_latency: early=%0b m_valid at N+3=%0b, required 0/1", early, bus.m_valid);
        else
            passed++;
        checks++;
        if (bus.dout_i !== 16'sd1000 || bus.dout_q !== -16'sd2000 || bus.sat_flag !== 1'b0)
            $display("FAIL identity_data: got i/q/sat=%0d/%0d/%0b, required 1000/-2000/0",
                     bus.dout_i, bus.dout_q, bus.sat_flag);
        else
            passed++;
        drain();
    endtask

    task automatic test_rotate_90();
        bus.m_ready = 1'b1;
        send(16'sd1000, 16'sd0, 16'sd0, 16'sd32767);
        wait_out();
        checks++;
        if (bus.dout_i !== 16'sd0 || bus.dout_q !== 16'sd1000 || bus.sat_flag !== 1'b0)
            $display("FAIL rot90_a: got i/q/sat=%0d/%0d/%0b, required 0/1000/0",
                     bus.dout_i, bus.dout_q, bus.sat_flag);
        else
            passed++;
        drain();
        send(16'sd0, 16'sd1000, 16'sd0, 16'sd32767);
        wait_out();
        checks++;
        if (bus.dout_i !== -16'sd1000 || bus.dout_q !== 16'sd0 || bus.sat_flag !== 1'b0)
            $display("FAIL rot90_b: got i/q/sat=%0d/%0d/%0b, required -1000/0/0",
                     bus.dout_i, bus.dout_q, bus.sat_flag);
        else
            passed++;
        drain();
    endtask

    task automatic test_saturation();
        bus.m_ready = 1'b1;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        checks++;
        if (sat_cnt !== '0) $display("FAIL sat_pre_clear: got %0d, required 0", sat_cnt);
        else passed++;
        send(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
        wait_out();
        checks++;
        if (bus.dout_i !== 16'sd0 || bus.dout_q !== 16'sd32767 || bus.sat_flag !== 1'b1)
            $display("FAIL sat_pos: got i/q/sat=%0d/%0d/%0b, required 0/32767/1",
                     bus.dout_i, bus.dout_q, bus.sat_flag);
        else
            passed++;
        drain();
        send(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0);
        wait_out();
        checks++;
        if (bus.dout_i !== 16'sd32767 || bus.dout_q !== 16'sd0 || bus.sat_flag !== 1'b1)
            $display("FAIL sat_negfs: got i/q/sat=%0d/%0d/%0b, required 32767/0/1",
                     bus.dout_i, bus.dout_q, bus.sat_flag);
        else
            passed++;
        drain();
        tick();
        checks++;
        if (sat_cnt !== C'(SAT_CNT_AFTER_TWO))
            $display("FAIL sat_cnt_two: got %0d, required %0d", sat_cnt, SAT_CNT_AFTER_TWO);
        else
            passed++;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        checks++;
        if (sat_cnt !== '0) $display("FAIL sat_cnt_clear: got %0d, required 0", sat_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] hi, hq;
        logic                hs;
        bit                  have;
        bus.m_ready = 1'b1;
        have = 1'b0;
        hi = '0;
        hq = '0;
        hs = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(W'($urandom), W'($urandom), D'($urandom), D'($urandom));
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                bus.m_ready = 1'b0;
                for (int cyc = 0; cyc < 10; cyc++) begin
                    tick();
                    if (bus.m_valid) begin
                        if (!have) begin
                            have = 1'b1;
                            hi = bus.dout_i;
                            hq = bus.dout_q;
                            hs = bus.sat_flag;
                        end else begin
                            checks++;
                            if (bus.dout_i !== hi || bus.dout_q !== hq || bus.sat_flag !== hs)
                                $display("FAIL bp_stable: got i/q/sat=%0d/%0d/%0b, required %0d/%0d/%0b",
                                         bus.dout_i, bus.dout_q, bus.sat_flag, hi, hq, hs);
                            else
                                passed++;
                        end
                    end
                end
                checks++;
                if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || exp_q.size() != 4)
                    $display("FAIL bp_full: s_ready/m_valid/held=%0b/%0b/%0d, required 0/1/4",
                             bus.s_ready, bus.m_valid, exp_q.size());
                else
                    passed++;
                bus.m_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 10000; k++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(W'($urandom), W'($urandom), D'($urandom), D'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.m_ready = ($urandom_range(0, 9) < 7);
                    tick();
                end
                bus.m_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_midflight();
        bit stale;
        bit early;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(16'sd100 * 16'(k + 1), 16'sd7, 16'sd32767, 16'sd0);
        tick();
        checks++;
        if (bus.m_valid !== 1'b1) $display("FAIL midrst_pre: m_valid=%0b, required 1", bus.m_valid);
        else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0)
            $display("FAIL midrst_async: m_valid/s_ready=%0b/%0b, required 0/0", bus.m_valid, bus.s_ready);
        else
            passed++;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.m_valid) stale = 1'b1;
        end
        checks++;
        if (stale) $display("FAIL midrst_stale: m_valid seen=1, required 0");
        else passed++;
        send(16'sd1234, -16'sd321, 16'sd32767, 16'sd0);
        early = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (bus.m_valid) early = 1'b1;
            tick();
        end
        if (bus.m_valid) early = 1'b1;
        tick();
        checks++;
        if (early || bus.m_valid !== 1'b1)
            $display("FAIL midrst_latency: early=%0b m_valid at N+3=%0b, required 0/1", early, bus.m_valid);
        else
            passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rotate_90();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
